// File: rtl/decode_regread_stage.sv
// -----------------------------------------------------------------------------
// decode_regread_stage
//
// Decode / register-read pipeline stage that sits between fetch and execute.
// It owns the NREG x DATA_W architectural register file. Each cycle it picks
// two read addresses out of the incoming instruction, reads the operands and
// registers them together with the addresses, the instruction and the pc.
//
// Register PC_REG is not a real storage entry: reading it returns
// pc_i + PC_OFFSET, and write-backs addressed to it are discarded.
//
// Optional feature (compile-time macro):
//   DECODE_WB_BYPASS_EN  defined   -> a read that hits the write-back address
//                                     of the same cycle returns wb_data_i
//                                     (write-first).
//                        undefined -> the read returns the old file contents
//                                     (read-first); execute must forward.
//   Operand refresh while stalled is present in both builds.
//
// Ports
//   clk_i      in   1       clock, all state updates on the rising edge
//   reset_i    in   1       synchronous active-high reset
//   pc_i       in   DATA_W  pc of inst_i
//   inst_i     in   32      instruction from fetch
//   valid_i    in   1       inst_i valid
//   stall_i    in   1       hold all output registers this cycle
//   flush_i    in   1       squash the instruction being captured
//   wb_en_i    in   1       write-back enable
//   wb_addr_i  in   REG_AW  write-back register index
//   wb_data_i  in   DATA_W  write-back data
//   valid_o    out  1       registered valid
//   inst_o     out  32      registered instruction
//   pc_o       out  DATA_W  registered pc
//   r1_o       out  DATA_W  operand 1 (Rd for load/store, else Rm)
//   r2_o       out  DATA_W  operand 2 (Rn)
//   r1_addr_o  out  REG_AW  registered operand 1 address
//   r2_addr_o  out  REG_AW  registered operand 2 address
//   rd_addr_o  out  REG_AW  registered inst[15:12]
// -----------------------------------------------------------------------------
module decode_regread_stage #(
    parameter int DATA_W    = 32,
    parameter int NREG      = 16,
    parameter int PC_REG    = 15,
    parameter int PC_OFFSET = 8,
    localparam int REG_AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              valid_o,
    output logic [31:0]       inst_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] r1_o,
    output logic [DATA_W-1:0] r2_o,
    output logic [REG_AW-1:0] r1_addr_o,
    output logic [REG_AW-1:0] r2_addr_o,
    output logic [REG_AW-1:0] rd_addr_o
);

    // Every address the index width can express gets a slot; slots that are
    // not real registers (beyond NREG, or the pc alias) read as zero.
    localparam int                NSLOT   = 1 << REG_AW;
    localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(PC_REG);

    // ------------------------------------------------------------------
    // Address decode. Fields are truncated to REG_AW bits when NREG < 16.
    // ------------------------------------------------------------------
    logic              is_ldst;
    logic [REG_AW-1:0] rn_sel;
    logic [REG_AW-1:0] rm_sel;
    logic [REG_AW-1:0] rd_sel;
    logic [REG_AW-1:0] r1_sel;
    logic [REG_AW-1:0] r2_sel;

    assign is_ldst = (inst_i[27:26] == 2'b01);
    assign rn_sel  = inst_i[16 +: REG_AW];
    assign rm_sel  = inst_i[0  +: REG_AW];
    assign rd_sel  = inst_i[12 +: REG_AW];
    assign r1_sel  = is_ldst ? rd_sel : rm_sel;
    assign r2_sel  = rn_sel;

    // A write-back aimed at the pc alias is dropped everywhere.
    logic wb_ok;
    assign wb_ok = wb_en_i && (wb_addr_i != PC_ADDR);

    // ------------------------------------------------------------------
    // Register file. Each entry is its own flop bank so the whole file can
    // be cleared by reset in one edge.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [NSLOT];

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_rf
            if ((gi < NREG) && (gi != PC_REG)) begin : g_entry
                logic [DATA_W-1:0] entry_reg;

                always_ff @(posedge clk_i) begin
                    if (reset_i) begin
                        entry_reg <= '0;
                    end else if (wb_ok && (wb_addr_i == REG_AW'(gi))) begin
                        entry_reg <= wb_data_i;
                    end
                end

                assign rf_q[gi] = entry_reg;
            end else begin : g_empty
                assign rf_q[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] pc_plus;
    logic [DATA_W-1:0] r1_next;
    logic [DATA_W-1:0] r2_next;

    // Wraps modulo 2^DATA_W by construction.
    assign pc_plus = pc_i + DATA_W'(PC_OFFSET);

    always_comb begin
        r1_next = rf_q[r1_sel];
        r2_next = rf_q[r2_sel];
`ifdef DECODE_WB_BYPASS_EN
        // Write-first: the value being written this edge is what gets captured.
        if (wb_ok && (wb_addr_i == r1_sel)) r1_next = wb_data_i;
        if (wb_ok && (wb_addr_i == r2_sel)) r2_next = wb_data_i;
`endif
        if (r1_sel == PC_ADDR) r1_next = pc_plus;
        if (r2_sel == PC_ADDR) r2_next = pc_plus;
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic              valid_reg;
    logic [31:0]       inst_reg;
    logic [DATA_W-1:0] pc_reg;
    logic [DATA_W-1:0] r1_reg;
    logic [DATA_W-1:0] r2_reg;
    logic [REG_AW-1:0] r1_addr_reg;
    logic [REG_AW-1:0] r2_addr_reg;
    logic [REG_AW-1:0] rd_addr_reg;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_reg   <= 1'b0;
            inst_reg    <= '0;
            pc_reg      <= '0;
            r1_reg      <= '0;
            r2_reg      <= '0;
            r1_addr_reg <= '0;
            r2_addr_reg <= '0;
            rd_addr_reg <= '0;
        end else if (flush_i || !stall_i) begin
            // A flush still loads the fields; only valid is squashed.
            valid_reg   <= valid_i && !flush_i;
            inst_reg    <= inst_i;
            pc_reg      <= pc_i;
            r1_reg      <= r1_next;
            r2_reg      <= r2_next;
            r1_addr_reg <= r1_sel;
            r2_addr_reg <= r2_sel;
            rd_addr_reg <= rd_sel;
        end else begin
            // Stalled: keep held operands coherent with write-backs that land
            // on the registers they came from.
            if (wb_ok && (wb_addr_i == r1_addr_reg)) r1_reg <= wb_data_i;
            if (wb_ok && (wb_addr_i == r2_addr_reg)) r2_reg <= wb_data_i;
        end
    end

    assign valid_o   = valid_reg;
    assign inst_o    = inst_reg;
    assign pc_o      = pc_reg;
    assign r1_o      = r1_reg;
    assign r2_o      = r2_reg;
    assign r1_addr_o = r1_addr_reg;
    assign r2_addr_o = r2_addr_reg;
    assign rd_addr_o = rd_addr_reg;

endmodule

// File: tb/tb_decode_regread_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_regread_stage
//
// Directed bench for decode_regread_stage (default parameters). Each step
// drives one cycle of inputs, pushes the expected register contents onto a
// scoreboard queue, then pops and compares them one time unit after the edge.
// Key points of the behaviour are also checked against literal constants.
// -----------------------------------------------------------------------------
module tb_decode_regread_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [3:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] r1_o;
    logic [31:0] r2_o;
    logic [3:0]  r1_addr_o;
    logic [3:0]  r2_addr_o;
    logic [3:0]  rd_addr_o;

    decode_regread_stage dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .pc_i      (pc_i),
        .inst_i    (inst_i),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .wb_en_i   (wb_en_i),
        .wb_addr_i (wb_addr_i),
        .wb_data_i (wb_data_i),
        .valid_o   (valid_o),
        .inst_o    (inst_o),
        .pc_o      (pc_o),
        .r1_o      (r1_o),
        .r2_o      (r2_o),
        .r1_addr_o (r1_addr_o),
        .r2_addr_o (r2_addr_o),
        .rd_addr_o (rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  r1a;
        logic [3:0]  r2a;
        logic [3:0]  rda;
    } out_t;

    out_t        sb[$];
    out_t        cur_exp = '0;
    logic [31:0] m_rf [16];
    int          errors = 0;
    int          checks = 0;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ALU-style instruction: bits[27:26]=00, operand 1 = Rm.
    function automatic logic [31:0] mk_alu(input logic [3:0] rn, input logic [3:0] rm);
        return {12'hE08, rn, 4'h0, 8'h00, rm};
    endfunction

    // Load/store instruction: bits[27:26]=01, operand 1 = Rd.
    function automatic logic [31:0] mk_ldst(input logic [3:0] rd, input logic [3:0] rn);
        return {8'hE5, 4'h9, rn, rd, 12'h004};
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd15) return pc_i + 32'd8;
        if (BYPASS && wb_en_i && (wb_addr_i == a)) return wb_data_i;
        return m_rf[a];
    endfunction

    task automatic set_in(input logic rst, input logic [31:0] inst, input logic [31:0] pc,
                          input logic vld, input logic stl, input logic fl,
                          input logic we, input logic [3:0] wa, input logic [31:0] wd);
        reset_i   = rst;
        inst_i    = inst;
        pc_i      = pc;
        valid_i   = vld;
        stall_i   = stl;
        flush_i   = fl;
        wb_en_i   = we;
        wb_addr_i = wa;
        wb_data_i = wd;
    endtask

    // One clock cycle: predict, push, clock, pop, compare.
    task automatic step(input string tag);
        out_t        n;
        out_t        e;
        logic [3:0]  a1;
        logic [3:0]  a2;
        n  = cur_exp;
        a1 = (inst_i[27:26] == 2'b01) ? inst_i[15:12] : inst_i[3:0];
        a2 = inst_i[19:16];
        if (reset_i) begin
            n = '0;
        end else if (flush_i || !stall_i) begin
            n.valid = valid_i && !flush_i;
            n.inst  = inst_i;
            n.pc    = pc_i;
            n.r1a   = a1;
            n.r2a   = a2;
            n.rda   = inst_i[15:12];
            n.r1    = m_read(a1);
            n.r2    = m_read(a2);
        end else begin
            if (wb_en_i && wb_addr_i != 4'd15 && wb_addr_i == n.r1a) n.r1 = wb_data_i;
            if (wb_en_i && wb_addr_i != 4'd15 && wb_addr_i == n.r2a) n.r2 = wb_data_i;
        end
        if (reset_i) begin
            for (int k = 0; k < 16; k++) m_rf[k] = '0;
        end else if (wb_en_i && wb_addr_i != 4'd15) begin
            m_rf[wb_addr_i] = wb_data_i;
        end
        cur_exp = n;
        sb.push_back(n);

        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e.valid});
        chk({tag, ".inst"},  inst_o, e.inst);
        chk({tag, ".pc"},    pc_o,   e.pc);
        chk({tag, ".r1"},    r1_o,   e.r1);
        chk({tag, ".r2"},    r2_o,   e.r2);
        chk({tag, ".r1a"},   {28'd0, r1_addr_o}, {28'd0, e.r1a});
        chk({tag, ".r2a"},   {28'd0, r2_addr_o}, {28'd0, e.r2a});
        chk({tag, ".rda"},   {28'd0, rd_addr_o}, {28'd0, e.rda});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16; k++) m_rf[k] = '0;

        // 1. Reset, then read every register.
        set_in(1, mk_alu(4'd1, 4'd2), 32'h40, 1, 0, 0, 1, 4'd1, 32'h1111);
        step("reset0");
        step("reset1");
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_r1", r1_o, 32'd0);
        set_in(0, 32'h0, 32'h0, 0, 0, 0, 0, 4'd0, 32'h0);
        step("post_reset");
        chk("post_reset_valid", {31'd0, valid_o}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            set_in(0, mk_alu(4'(i), 4'(i)), 32'h0, 1, 0, 0, 0, 4'd0, 32'h0);
            step($sformatf("read_r%0d", i));
        end

        // 2. Write-back then read on the following cycle.
        set_in(0, 32'h0, 32'h0, 0, 0, 0, 1, 4'd3, 32'hDEADBEEF);
        step("wb_r3");
        set_in(0, mk_alu(4'd3, 4'd3), 32'h10, 1, 0, 0, 0, 4'd0, 32'h0);
        step("read_r3");
        chk("r3_r1", r1_o, 32'hDEADBEEF);
        chk("r3_r2", r2_o, 32'hDEADBEEF);
        chk("r3_valid", {31'd0, valid_o}, 32'd1);

        // 3. Same-cycle write-back and read of r5.
        set_in(0, mk_alu(4'd5, 4'd5), 32'h14, 1, 0, 0, 1, 4'd5, 32'h1234);
        step("hazard_r5");
        chk("hazard_r2", r2_o, BYPASS ? 32'h1234 : 32'h0);
        set_in(0, mk_alu(4'd5, 4'd0), 32'h18, 1, 0, 0, 0, 4'd0, 32'h0);
        step("reread_r5");
        chk("reread_r2", r2_o, 32'h1234);

        // 4. PC alias reads, dropped write, wrap-around.
        set_in(0, mk_alu(4'd15, 4'd15), 32'h100, 1, 0, 0, 0, 4'd0, 32'h0);
        step("pc_read");
        chk("pc_r2", r2_o, 32'h108);
        set_in(0, 32'h0, 32'h0, 0, 0, 0, 1, 4'd15, 32'h55);
        step("wb_r15");
        set_in(0, mk_alu(4'd15, 4'd0), 32'h100, 1, 0, 0, 0, 4'd0, 32'h0);
        step("pc_read2");
        chk("pc_r2_after_wb", r2_o, 32'h108);
        set_in(0, mk_alu(4'd15, 4'd15), 32'hFFFF_FFFC, 1, 0, 0, 0, 4'd0, 32'h0);
        step("pc_wrap");
        chk("pc_wrap_r1", r1_o, 32'h4);

        // 5. Load/store decode and stall with refresh.
        set_in(0, 32'h0, 32'h0, 0, 0, 0, 1, 4'd2, 32'hAAAA);
        step("wb_r2");
        set_in(0, mk_ldst(4'd2, 4'd4), 32'h200, 1, 0, 0, 0, 4'd0, 32'h0);
        step("ldst");
        chk("ldst_r1a", {28'd0, r1_addr_o}, 32'd2);
        chk("ldst_r2a", {28'd0, r2_addr_o}, 32'd4);
        set_in(0, mk_alu(4'd7, 4'd8), 32'h204, 1, 1, 0, 0, 4'd0, 32'h0);
        step("stall1");
        set_in(0, mk_alu(4'd7, 4'd8), 32'h204, 1, 1, 0, 1, 4'd4, 32'h77);
        step("stall2_wb");
        set_in(0, mk_alu(4'd7, 4'd8), 32'h204, 1, 1, 0, 0, 4'd0, 32'h0);
        step("stall3");
        chk("stall_r2", r2_o, 32'h77);
        chk("stall_r1", r1_o, 32'hAAAA);
        chk("stall_pc", pc_o, 32'h200);

        // Both operands from one register refresh together.
        set_in(0, mk_alu(4'd6, 4'd6), 32'h300, 1, 0, 0, 0, 4'd0, 32'h0);
        step("same_addr");
        set_in(0, mk_alu(4'd9, 4'd9), 32'h304, 1, 1, 0, 1, 4'd6, 32'h99);
        step("same_addr_stall");
        chk("both_r1", r1_o, 32'h99);
        chk("both_r2", r2_o, 32'h99);

        // 6. Flush beats stall; reset beats stall.
        set_in(0, mk_alu(4'd3, 4'd2), 32'h400, 1, 1, 1, 0, 4'd0, 32'h0);
        step("flush_stall");
        chk("flush_valid", {31'd0, valid_o}, 32'd0);
        chk("flush_pc", pc_o, 32'h400);
        set_in(0, mk_alu(4'd3, 4'd2), 32'h404, 1, 0, 0, 0, 4'd0, 32'h0);
        step("pre_reset");
        set_in(1, mk_alu(4'd3, 4'd2), 32'h408, 1, 1, 0, 1, 4'd3, 32'hBAD);
        step("reset_stall");
        chk("rst_stall_inst", inst_o, 32'h0);
        chk("rst_stall_r1", r1_o, 32'h0);
        set_in(0, mk_alu(4'd3, 4'd2), 32'h40C, 1, 0, 0, 0, 4'd0, 32'h0);
        step("after_reset");
        chk("rf_cleared_r2", r2_o, 32'h0);

        // Mixed random traffic checked against the model.
        for (int i = 0; i < 60; i++) begin
            set_in(($urandom_range(0, 29) == 0), $urandom, $urandom,
                   1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                   1'($urandom), 4'($urandom), $urandom);
            step($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
